// File: rtl/riscv_pkg.sv
// Shared integer-core types for the register-file write path.
package riscv_pkg;

    typedef logic [4:0]  rf_addr_t;
    typedef logic [31:0] xlen_t;

    typedef enum logic {
        ST_PIPE_PRI = 1'b0,
        ST_MC_FORCE = 1'b1
    } arb_state_e;

    localparam rf_addr_t REG_X0 = 5'd0;

endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Pending-destination scoreboard: one busy bit per integer register, set when
// a multi-cycle op issues and cleared when its result is written back.
module riscv_rf_scoreboard
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        set_valid,
    input  rf_addr_t    set_addr,
    input  logic        clr_valid,
    input  rf_addr_t    clr_addr,
    output logic [31:0] busy_mask
);

    logic [31:0] set_vec;
    logic [31:0] clr_vec;

    // Decode set/clear requests into one-hot vectors; x0 never marks busy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        set_vec = '0;
        clr_vec = '0;
        if (set_valid && (set_addr != REG_X0)) set_vec = 32'd1 << set_addr;
        if (clr_valid) clr_vec = 32'd1 << clr_addr;
    end

    // Clear first, then OR in the set so a same-cycle issue to the written register wins.
    always_ff @(posedge clk) begin
        // NOTE: the busy mask is ordinary control state, so it is reset; sequential updates use <= only.
        if (!reset_n) busy_mask <= '0;
        else          busy_mask <= ((busy_mask & ~clr_vec) | set_vec) & ~32'd1;
    end

endmodule

// File: rtl/riscv_rf_write_arbiter.sv
// Register-file write-port arbiter: the writeback pipe has fixed priority, and
// the multi-cycle unit is forced through after MAX_WAIT consecutive denials.
// Writes to x0 are accepted immediately and never use the port.
// Optional build macro RF_WRITE_PERF_CNT_EN adds saturating stall/wait counters.
module riscv_rf_write_arbiter
    import riscv_pkg::*;
#(
    parameter  int unsigned MAX_WAIT = 4,
    localparam int unsigned WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pipe_valid,
    input  rf_addr_t    pipe_addr,
    input  xlen_t       pipe_data,
    output logic        pipe_ready,
    input  logic        mc_valid,
    input  rf_addr_t    mc_addr,
    input  xlen_t       mc_data,
    output logic        mc_ready,
    input  logic        mc_issue_valid,
    input  rf_addr_t    mc_issue_addr,
    output logic [31:0] busy_mask,
`ifdef RF_WRITE_PERF_CNT_EN
    output logic [31:0] perf_pipe_stall_cnt,
    output logic [31:0] perf_mc_wait_cnt,
`endif
    output logic        rf_we,
    output rf_addr_t    rf_addr,
    output xlen_t       rf_data
);

    arb_state_e        state;
    logic [WAIT_W-1:0] wait_cnt;

    logic pipe_nz;
    logic mc_nz;
    logic pipe_fire;
    logic mc_fire;
    logic mc_denied;

    // Ready generation: pipe wins unless the multi-cycle unit is being forced.
    always_comb begin
        pipe_nz = pipe_valid && (pipe_addr != REG_X0);
        mc_nz   = mc_valid && (mc_addr != REG_X0);
        if (state == ST_MC_FORCE) begin
            pipe_ready = !pipe_nz;
            mc_ready   = 1'b1;
        end else begin
            pipe_ready = 1'b1;
            mc_ready   = !pipe_nz || (mc_addr == REG_X0);
        end
        pipe_fire = pipe_nz && pipe_ready;
        mc_fire   = mc_nz && mc_ready;
        mc_denied = mc_valid && !mc_ready;
    end

    // Arbiter FSM: count consecutive mc denials and force one grant at the limit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_PIPE_PRI;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_PIPE_PRI: begin
                    if (mc_denied) begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) state <= ST_MC_FORCE;
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                ST_MC_FORCE: begin
                    // Granted or (illegally) withdrawn: either way priority reverts to the pipe.
                    state    <= ST_PIPE_PRI;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= ST_PIPE_PRI;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Registered write port; address/data hold their last value between writes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rf_we   <= 1'b0;
            rf_addr <= REG_X0;
            rf_data <= '0;
        end else begin
            rf_we <= pipe_fire || mc_fire;
            if (pipe_fire) begin
                rf_addr <= pipe_addr;
                rf_data <= pipe_data;
            end else if (mc_fire) begin
                rf_addr <= mc_addr;
                rf_data <= mc_data;
            end
        end
    end

    riscv_rf_scoreboard u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_valid (mc_issue_valid),
        .set_addr  (mc_issue_addr),
        .clr_valid (mc_fire),
        .clr_addr  (mc_addr),
        .busy_mask (busy_mask)
    );

`ifdef RF_WRITE_PERF_CNT_EN
    // Saturating performance counters for pipe stalls and mc wait cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_pipe_stall_cnt <= '0;
            perf_mc_wait_cnt    <= '0;
        end else begin
            if (pipe_valid && !pipe_ready && (perf_pipe_stall_cnt != 32'hFFFF_FFFF))
                perf_pipe_stall_cnt <= perf_pipe_stall_cnt + 32'd1;
            if (mc_denied && (perf_mc_wait_cnt != 32'hFFFF_FFFF))
                perf_mc_wait_cnt <= perf_mc_wait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/riscv_rf_write_arbiter.md
Name: riscv_rf_write_arbiter

Overview:
Arbitrates the single integer register-file write port between the in-order writeback stage and the multi-cycle unit (divider / late load return). The block sits between the writeback pipeline register and the register file. It applies fixed pipeline priority with a bounded-starvation override for the multi-cycle unit. It also keeps a pending-destination scoreboard that decode uses for RAW/WAW hazard stalls.

Parameters:
MAX_WAIT, 4, cycles a valid multi-cycle request may be denied before it is forced through; legal range 1..255.
WAIT_W, $clog2(MAX_WAIT+1), width of the wait counter; derived, never overridden.

Ports:
clk  in  1  core clock
reset_n  in  1  synchronous active-low reset, sampled on posedge clk
pipe_valid  in  1  writeback stage has a result
pipe_addr  in  5  destination register
pipe_data  in  32  result data
pipe_ready  out  1  writeback result accepted this cycle
mc_valid  in  1  multi-cycle unit has a result
mc_addr  in  5  destination register
mc_data  in  32  result data
mc_ready  out  1  multi-cycle result accepted this cycle
mc_issue_valid  in  1  multi-cycle op issued this cycle
mc_issue_addr  in  5  its destination register
busy_mask  out  32  bit n set = xn has an outstanding multi-cycle write
rf_we  out  1  register-file write enable
rf_addr  out  5  register-file write address
rf_data  out  32  register-file write data

Behaviour:
- Single clock domain. Reset is synchronous and active-low (reset_n sampled on posedge clk).
- Reset values: rf_we=0, rf_addr=0, rf_data=0, busy_mask=0, state=ST_PIPE_PRI, wait_cnt=0.
- Reset mid-transfer drops any pending requests silently.
- Handshake: valid/ready. A transfer occurs when valid&ready. Requesters hold addr and data stable while valid&~ready. pipe_ready and mc_ready are combinational from the current state and valids.
- Writes to x0: a request with addr==0 is accepted as soon as it is offered (ready=1), produces no rf_we, and does not consume the port.
- Latency: an accepted non-x0 write appears on rf_we/rf_addr/rf_data on the next posedge. Outputs are registered, and rf_we is high for exactly one cycle per write. At most one write is issued per cycle.
- FSM, two states:
  - ST_PIPE_PRI: pipe_ready=1. mc_ready = ~(pipe_valid & pipe_addr!=0).
    - wait_cnt increments each cycle that mc_valid&~mc_ready; it clears on any mc transfer or when mc_valid=0.
    - When wait_cnt==MAX_WAIT-1 and mc is denied again, go to ST_MC_FORCE.
  - ST_MC_FORCE: mc_ready=1. pipe_ready = (pipe_addr==0) | ~pipe_valid, so a non-x0 pipe write is stalled.
    - On mc transfer, return to ST_PIPE_PRI with wait_cnt=0.
    - If mc_valid=0 (protocol violation), return to ST_PIPE_PRI with no write.
- Guaranteed bound: a valid mc request is granted within MAX_WAIT+1 cycles.
- Scoreboard:
  - Set bit a on mc_issue_valid with mc_issue_addr==a, a!=0.
  - Clear bit a at the same edge that captures an mc write to a.
  - Simultaneous set and clear of the same a: set wins.
  - Issue to an already-busy register: the bit stays set, no error.
  - Pipe writes never change busy_mask.
  - Bit 0 is always 0.

Optional Feature:
RF_WRITE_PERF_CNT_EN
- Defined: adds outputs perf_pipe_stall_cnt[31:0] (cycles pipe_valid&~pipe_ready) and perf_mc_wait_cnt[31:0] (cycles mc_valid&~mc_ready). Both are 0 at reset, saturate at 32'hFFFF_FFFF, and are registered.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package riscv_pkg holds: the rf_addr_t (5-bit) and xlen_t (32-bit) typedefs, the arb_state_e enum {ST_PIPE_PRI, ST_MC_FORCE}, and constant REG_X0=5'd0.
- One natural sub-module: riscv_rf_scoreboard. It contains the 32-bit busy mask with set/clear ports and implements the set-wins rule. The arbiter FSM and output register stay in the top module.

Test Plan:
1. Reset with reset_n=0 for 2 cycles while pipe_valid=1, addr=5 -> rf_we=0 and busy_mask=0 throughout reset; the first write, x5, appears on the cycle after release.
2. pipe x3=32'hA5A5_0001 and mc x4=32'h0000_0042 offered together, MAX_WAIT=4 -> x3 is written at cycle+1, then mc is written on the first cycle the pipe is idle.
3. pipe writes continuously to x7 and mc holds x9 -> mc is denied 4 cycles, then ST_MC_FORCE stalls the pipe for 1 cycle, rf_we writes x9, and the pipe resumes next cycle.
4. mc_issue_valid x12 -> busy_mask=32'h0000_1000; the mc write to x12 clears it at the same edge rf_we rises. Issue of x12 in the same cycle as an mc write to x12 -> the bit stays 1.
5. pipe and mc both target x0 with data 32'hDEAD_BEEF -> both ready=1 the same cycle, no rf_we, busy_mask unchanged. Issue of x0 -> busy_mask bit 0 stays 0.
6. With RF_WRITE_PERF_CNT_EN defined, scenario 3 -> perf_mc_wait_cnt=4 and perf_pipe_stall_cnt=1.
